// File: rtl/led_seq_sched_if.sv
// Control, table-write and LED output bundle for the LED sequencing controller.
interface led_seq_sched_if #(
  parameter int W     = 3,
  parameter int DEPTH = 8
);
  logic                     start;
  logic                     halt;
  logic                     stop;
  logic                     step;
  logic                     wr_en;
  logic [$clog2(DEPTH)-1:0] wr_addr;
  logic [W-1:0]             wr_data;
  logic                     wr_ready;
  logic [W-1:0]             led;
  logic                     busy;
  logic                     wrap;

  modport master (
    output start, halt, stop, step, wr_en, wr_addr, wr_data,
    input  wr_ready, led, busy, wrap
  );

  modport slave (
    input  start, halt, stop, step, wr_en, wr_addr, wr_data,
    output wr_ready, led, busy, wrap
  );
endinterface

// File: rtl/led_seq_sched.sv
// Table-driven LED sequencer with run/pause/stop/single-step control and a host write port.
// Define LED_SEQ_PINGPONG_EN to make the pointer bounce between the table ends instead of wrapping.
//
// state | meaning
// IDLE  | stopped, ptr=0, table writable
// RUN   | ptr advances every DIV cycles, table locked
// PAUSE | ptr held, single-step allowed, table writable
module led_seq_sched #(
  parameter int W     = 3,
  parameter int DEPTH = 8,
  parameter int DIV   = 4
) (
  input logic            clk,
  input logic            reset,
  led_seq_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  ptr, ptr_nxt;
  logic [DW-1:0]  div, div_nxt;
  logic           adv, clr;
  logic           wrap_pulse, wrap_nxt;
  logic [W-1:0]   tbl [DEPTH];
`ifdef LED_SEQ_PINGPONG_EN
  logic           down, down_nxt;
`endif

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    adv       = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.stop) begin
          clr = 1'b1;
        end else if (bus.start) begin
          state_nxt = RUN;
          div_nxt   = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          clr       = 1'b1;
          div_nxt   = '0;
        end else if (bus.halt) begin
          state_nxt = PAUSE;
          div_nxt   = '0;
        end else if (div == DW'(DIV - 1)) begin
          div_nxt = '0;
          adv     = 1'b1;
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          clr       = 1'b1;
          div_nxt   = '0;
        end else if (bus.start) begin
          state_nxt = RUN;
          div_nxt   = '0;
        end else if (bus.step) begin
          adv = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        clr       = 1'b1;
        div_nxt   = '0;
      end
    endcase
  end

  // A stop returns ptr to 0 without a wrap pulse.
  always_comb begin
    ptr_nxt  = ptr;
    wrap_nxt = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
    down_nxt = down;
    if (clr) begin
      ptr_nxt  = '0;
      down_nxt = 1'b0;
    end else if (adv) begin
      if (!down) begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == AW'(DEPTH - 2)) begin
          down_nxt = 1'b1;
          wrap_nxt = 1'b1;
        end
      end else begin
        ptr_nxt = ptr - 1'b1;
        if (ptr == AW'(1)) begin
          down_nxt = 1'b0;
          wrap_nxt = 1'b1;
        end
      end
    end
`else
    if (clr) begin
      ptr_nxt = '0;
    end else if (adv) begin
      ptr_nxt  = ptr + 1'b1;
      wrap_nxt = (ptr == AW'(DEPTH - 1));
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      div        <= '0;
      wrap_pulse <= 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
      down       <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) tbl[i] <= W'(5 * i + 3);
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      div        <= div_nxt;
      wrap_pulse <= wrap_nxt;
`ifdef LED_SEQ_PINGPONG_EN
      down       <= down_nxt;
`endif
      if (bus.wr_en && bus.wr_ready) tbl[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.led      = tbl[ptr];
  assign bus.busy     = (state == RUN);
  assign bus.wr_ready = (state != RUN);
  assign bus.wrap     = wrap_pulse;
endmodule

// File: tb/tb_led_seq_sched.sv
// Randomized and directed bench for led_seq_sched: a cycle-level reference model queues expected
// outputs, and a monitor compares them one clock later.
module tb_led_seq_sched;
  localparam int W     = 3;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;
  localparam int AW    = $clog2(DEPTH);
`ifdef LED_SEQ_PINGPONG_EN
  localparam int PERIOD = 2 * DEPTH - 2;
  localparam bit PP     = 1'b1;
`else
  localparam int PERIOD = DEPTH;
  localparam bit PP     = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  led_seq_sched_if #(.W(W), .DEPTH(DEPTH)) bus ();

  led_seq_sched #(.W(W), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [W-1:0] led;
    logic         busy;
    logic         wrap;
    logic         wr_ready;
  } obs_t;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;

  obs_t  exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  mode_t mode;
  int    cnt;
  int    pos;
  int    tbl[DEPTH];

  // Position along the visiting order; in ping-pong mode the second half walks back down.
  function automatic int ptr_of(int p);
    return (p < DEPTH) ? p : (2 * (DEPTH - 1) - p);
  endfunction

  task automatic model_reset();
    mode = M_IDLE;
    cnt  = 0;
    pos  = 0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = (5 * i + 3) % (1 << W);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cyc(input bit go, input bit hl, input bit sp, input bit stp,
                     input bit we, input int a, input int d);
    bit   adv;
    bit   wrp;
    bit   ok;
    int   p;
    obs_t e;
    @(negedge clk);
    bus.start   = go;
    bus.halt    = hl;
    bus.stop    = sp;
    bus.step    = stp;
    bus.wr_en   = we;
    bus.wr_addr = AW'(a);
    bus.wr_data = W'(d);
    adv = 1'b0;
    wrp = 1'b0;
    ok  = we && (mode != M_RUN);
    case (mode)
      M_IDLE: begin
        if (sp) pos = 0;
        else if (go) begin mode = M_RUN; cnt = 0; end
      end
      M_RUN: begin
        if (sp) begin mode = M_IDLE; pos = 0; cnt = 0; end
        else if (hl) begin mode = M_PAUSE; cnt = 0; end
        else if (cnt == DIV - 1) begin cnt = 0; adv = 1'b1; end
        else cnt++;
      end
      default: begin
        if (sp) begin mode = M_IDLE; pos = 0; end
        else if (go) begin mode = M_RUN; cnt = 0; end
        else if (stp) adv = 1'b1;
      end
    endcase
    if (ok) tbl[a] = d % (1 << W);
    if (adv) begin
      pos = (pos + 1) % PERIOD;
      p   = ptr_of(pos);
      wrp = (p == 0) || (PP && p == DEPTH - 1);
    end
    e.led      = W'(tbl[ptr_of(pos)]);
    e.busy     = (mode == M_RUN);
    e.wrap     = wrp;
    e.wr_ready = (mode != M_RUN);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.led, bus.busy, bus.wrap, bus.wr_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got led=%0d busy=%0b wrap=%0b wr_ready=%0b want led=%0d busy=%0b wrap=%0b wr_ready=%0b",
                 $time, a.led, a.busy, a.wrap, a.wr_ready, e.led, e.busy, e.wrap, e.wr_ready);
      end
    end
  end

  initial begin
    bus.start   = 1'b0;
    bus.halt    = 1'b0;
    bus.stop    = 1'b0;
    bus.step    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    model_reset();
    #12;
    chk("reset_led", int'(bus.led), 3);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_wrap", int'(bus.wrap), 0);
    chk("reset_wr_ready", int'(bus.wr_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    // Full lap from reset, including the wrap back to entry 0.
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(36);
    // Halt, single steps, resume.
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(8);
    // Reprogram in PAUSE, including a write coinciding with a step.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 2, 7);
    cyc(0, 0, 0, 1, 1, 3, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(34);
    // Write while running must be dropped.
    cyc(0, 0, 0, 0, 1, 0, 5);
    idle(34);
    // Conflicting commands in RUN: stop wins.
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(6);

    // Asynchronous reset between edges while running.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_led", int'(bus.led), 3);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_wrap", int'(bus.wrap), 0);
    chk("async_wr_ready", int'(bus.wr_ready), 1);
    model_reset();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(34);

    repeat (1200) begin
      cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
          $urandom_range(0, DEPTH - 1), $urandom_range(0, (1 << W) - 1));
    end

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_seq_sched.md
# led_seq_sched

Sequencing controller for the 3-bit LED counter datapath: holds a small programmable table of LED codes and steps through it at a divided rate, with run/pause/stop/single-step control and a write port for reprogramming the sequence while not running. It sits between the board-level control inputs and the LED pins. It replaces a hard-wired "random" counter sequence with a table-driven one that a host can load.

## Interface
- W, 3, LED code width.
- DEPTH, 8, table entries; power of two, ≥2.
- DIV, 4, clock cycles per sequence step in RUN; ≥1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled; IDLE→RUN, PAUSE→RUN.
- halt  in  1  RUN→PAUSE.
- stop  in  1  any state→IDLE, pointer to 0.
- step  in  1  in PAUSE: advance one entry.
- wr_en  in  1  table write strobe; honoured only when wr_ready=1.
- wr_addr  in  $clog2(DEPTH)  table write address.
- wr_data  in  W  table write data.
- wr_ready  out  1  1 in IDLE and PAUSE, 0 in RUN.
- led  out  W  table[ptr]; combinational from ptr and table flops.
- busy  out  1  1 in RUN.
- wrap  out  1  one-cycle pulse on the cycle after ptr returns to 0 (or turns, see Configuration).

## Operation
- States: IDLE (reset), RUN, PAUSE. State register, ptr, div counter, table all async-reset.
- Reset table: entry i = (5*i+3) mod 2^W (DEPTH=8, W=3: 3,0,5,2,7,4,1,6). Reset: ptr=0, div=0, led=3, busy=0, wrap=0, wr_ready=1.
- Command priority per cycle: stop > halt > start > step. Inputs meaningless in a state are ignored.
- IDLE: start → RUN, div=0. step, halt ignored.
- RUN: div counts 0..DIV-1; at div=DIV-1 the next edge sets div=0 and advances ptr. halt → PAUSE, div cleared, ptr held. stop → IDLE, ptr=0, div=0.
- PAUSE: step → ptr advances one entry on that edge (wrap rules apply). start → RUN, div=0. stop → IDLE.
- Pointer advance: ptr+1, DEPTH-1 wraps to 0 and raises wrap for one cycle. Stop-to-0 never raises wrap.
- Writes: table[wr_addr] <= wr_data on edge where wr_en && wr_ready. A write to the current ptr changes led the same edge. wr_en in RUN is dropped silently (no queueing).
- Simultaneous write and step in PAUSE: both take effect; led shows table[new ptr] with the write applied.

## Timing
- RUN step period exactly DIV cycles; first advance DIV cycles after the edge that entered RUN.
- led changes on the same edge ptr or the addressed entry changes; zero added latency.
- wrap asserted during the cycle following the wrapping edge, deasserted one cycle later unless wrapping again (DIV=1, DEPTH=2 can give back-to-back pulses).
- Reset mid-RUN: all outputs return to reset values immediately (asynchronous), independent of clk.
- busy/wr_ready update on the state-transition edge.

## Configuration
- LED_SEQ_PINGPONG_EN defined: ptr bounces 0→DEPTH-1→0 with an internal direction flop (reset: up; stop resets to up). wrap pulses on each turn, at ptr=DEPTH-1 and at ptr=0. Each end entry is shown for one step only.
- Undefined: ptr wraps DEPTH-1→0 as above; no direction flop.

## Test plan
- Reset then start, DIV=4: led sequence 3,0,5,2,7,4,1,6,3 changing every 4 cycles. wrap pulses once after 6→3.
- Run 2 steps (led=5), halt, 3×step: led 2,7,4 each on the step edge. start resumes with next change 4 cycles later.
- In PAUSE write addr 2=7 and addr 3=1, stop, start: sequence 3,0,7,1,7,4,1,6. wr_en in RUN to addr 0 leaves entry 0 at 3.
- halt, start and stop asserted in the same cycle during RUN: state IDLE, ptr=0, led=3, busy=0.
- Assert reset mid-step between clock edges: led=3, busy=0, wrap=0 before next edge. Table restored to defaults.
- With LED_SEQ_PINGPONG_EN: led 3,0,5,2,7,4,1,6,1,4,… with wrap pulses after reaching 6 and after returning to 3.
